// File: rtl/mdio_controller_if.sv
// Signal bundle between the host/receiver side and the MDIO station controller.
interface mdio_controller_if;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned RD_W   = 16;

  logic              mdio_start;
  logic [WORD_W-1:0] t_data;
  logic              mdio_in;
  logic              mdc;
  logic              mdio_oe;
  logic              mdio_out;
  logic [RD_W-1:0]   rd_data;
  logic              data_rdy;
  logic              busy;

  // Host and receiver side: issues transactions, returns read bits.
  modport master (
    output mdio_start, t_data, mdio_in,
    input  mdc, mdio_oe, mdio_out, rd_data, data_rdy, busy
  );

  // Controller side.
  modport slave (
    input  mdio_start, t_data, mdio_in,
    output mdc, mdio_oe, mdio_out, rd_data, data_rdy, busy
  );
endinterface

// File: rtl/mdio_controller.sv
// MDIO station controller: serialises a 32-bit frame with a generated MDC
// and, for reads, turns the line around and shifts in 16 data bits.
module mdio_controller #(
  parameter int unsigned DIV = 1
) (
  input  logic             clk,
  input  logic             rst,
  mdio_controller_if.slave bus
);
  localparam int unsigned DIV_W  = $clog2(DIV) + 1;
  localparam int unsigned BIT_W  = 5;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned RD_W   = 16;
  localparam logic [1:0]  OP_RD  = 2'b10;

  typedef enum logic [1:0] {IDLE, WRITE, READ_DRV, READ_SMP} state_t;

  state_t            state_q, state_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [BIT_W-1:0]  bit_q, bit_d, bit_inc;
  logic [WORD_W-1:0] word_q, word_d;
  logic [RD_W-1:0]   shift_q, shift_d;
  logic [RD_W-1:0]   rd_q, rd_d;
  logic              mdc_q, mdc_d;
  logic              oe_q, oe_d;
  logic              out_q, out_d;
  logic              rdy_q, rdy_d;
  logic              busy_q, busy_d;
  logic              tick;

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      word_q  <= '0;
      shift_q <= '0;
      rd_q    <= '0;
      mdc_q   <= 1'b0;
      oe_q    <= 1'b0;
      out_q   <= 1'b0;
      rdy_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      word_q  <= word_d;
      shift_q <= shift_d;
      rd_q    <= rd_d;
      mdc_q   <= mdc_d;
      oe_q    <= oe_d;
      out_q   <= out_d;
      rdy_q   <= rdy_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state and output logic; every MDC half-period ends on a tick.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    word_d  = word_q;
    shift_d = shift_q;
    rd_d    = rd_q;
    mdc_d   = mdc_q;
    oe_d    = oe_q;
    out_d   = out_q;
    rdy_d   = 1'b0;
    busy_d  = busy_q;
    tick    = (div_q == DIV_W'(DIV - 1));
    bit_inc = bit_q + BIT_W'(1);

    case (state_q)
      IDLE: begin
        if (bus.mdio_start) begin
          word_d  = bus.t_data;
          busy_d  = 1'b1;
          oe_d    = 1'b1;
          out_d   = bus.t_data[WORD_W-1];
          mdc_d   = 1'b0;
          div_d   = '0;
          bit_d   = '0;
          shift_d = '0;
          state_d = (bus.t_data[29:28] == OP_RD) ? READ_DRV : WRITE;
        end
      end
      default: begin
        if (!tick) begin
          div_d = div_q + DIV_W'(1);
        end else begin
          div_d = '0;
          mdc_d = ~mdc_q;
          if (!mdc_q) begin
            // Rising MDC: the receiver's bit is valid now.
            if (state_q == READ_SMP) shift_d = {shift_q[RD_W-2:0], bus.mdio_in};
          end else if (bit_q == BIT_W'(WORD_W - 1)) begin
            state_d = IDLE;
            mdc_d   = 1'b0;
            oe_d    = 1'b0;
            out_d   = 1'b0;
            busy_d  = 1'b0;
            bit_d   = '0;
            if (state_q == READ_SMP) begin
              rd_d  = shift_q;
              rdy_d = 1'b1;
            end
          end else begin
            // Falling MDC opens the next bit cycle; 31-k is the bitwise inverse of k.
            bit_d = bit_inc;
            if (state_q == READ_DRV && bit_inc == BIT_W'(RD_W)) begin
              oe_d    = 1'b0;
              out_d   = 1'b0;
              state_d = READ_SMP;
            end else if (state_q != READ_SMP) begin
              out_d = word_q[~bit_inc];
            end
          end
        end
      end
    endcase
  end

  assign bus.mdc      = mdc_q;
  assign bus.mdio_oe  = oe_q;
  assign bus.mdio_out = out_q;
  assign bus.rd_data  = rd_q;
  assign bus.data_rdy = rdy_q;
  assign bus.busy     = busy_q;
endmodule

// File: tb/tb_mdio_controller.sv
// Bench for mdio_controller: DIV=1 and DIV=3 instances share stimulus and are
// checked every cycle against a frame-timing model, plus literal spot checks.
module tb_mdio_controller;
  localparam int NDUT = 2;
  localparam int DIVS [NDUT] = '{1, 3};

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] t_data;
  logic        rx_bit  [NDUT];
  logic [15:0] rx_word [NDUT];
  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;

  always #5 clk = ~clk;

  mdio_controller_if u_if1 ();
  mdio_controller_if u_if3 ();

  mdio_controller #(.DIV(1)) u_dut1 (.clk(clk), .rst(rst), .bus(u_if1.slave));
  mdio_controller #(.DIV(3)) u_dut3 (.clk(clk), .rst(rst), .bus(u_if3.slave));

  assign u_if1.mdio_start = start;
  assign u_if3.mdio_start = start;
  assign u_if1.t_data     = t_data;
  assign u_if3.t_data     = t_data;
  assign u_if1.mdio_in    = rx_bit[0];
  assign u_if3.mdio_in    = rx_bit[1];

  logic [NDUT-1:0] a_mdc, a_oe, a_out, a_rdy, a_busy;
  logic [15:0]     a_rd [NDUT];
  assign a_mdc  = {u_if3.mdc,      u_if1.mdc};
  assign a_oe   = {u_if3.mdio_oe,  u_if1.mdio_oe};
  assign a_out  = {u_if3.mdio_out, u_if1.mdio_out};
  assign a_rdy  = {u_if3.data_rdy, u_if1.data_rdy};
  assign a_busy = {u_if3.busy,     u_if1.busy};
  assign a_rd[0] = u_if1.rd_data;
  assign a_rd[1] = u_if3.rd_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: a frame is 64*DIV clocks from the accepting edge; outputs follow from n.
  logic        m_act  [NDUT];
  int          m_n    [NDUT];
  logic [31:0] m_word [NDUT];
  logic [15:0] m_rd   [NDUT];
  logic        m_rdy  [NDUT];
  logic        prev_mdc [NDUT];
  int          rx_idx [NDUT];
  logic        e_mdc, e_oe, e_out, e_busy, is_rd;
  int          k;

  initial begin
    for (int i = 0; i < NDUT; i++) begin
      m_act[i] = 1'b0; m_n[i] = 0; m_word[i] = '0; m_rd[i] = '0; m_rdy[i] = 1'b0;
      prev_mdc[i] = 1'b0; rx_idx[i] = 0; rx_bit[i] = 1'b0; rx_word[i] = '0;
    end
  end

  always @(posedge clk) begin
    cyc = cyc + 1;
    for (int i = 0; i < NDUT; i++) begin
      m_rdy[i] = 1'b0;
      if (rst) begin
        m_act[i] = 1'b0; m_n[i] = 0; m_rd[i] = '0;
      end else if (m_act[i]) begin
        m_n[i] = m_n[i] + 1;
        if (m_n[i] == 64 * DIVS[i]) begin
          m_act[i] = 1'b0;
          if (m_word[i][29:28] == 2'b10) begin
            m_rd[i]  = rx_word[i];
            m_rdy[i] = 1'b1;
          end
        end
      end else if (start) begin
        m_act[i] = 1'b1; m_n[i] = 0; m_word[i] = t_data;
      end
    end
    #1;
    for (int i = 0; i < NDUT; i++) begin
      if (m_act[i]) begin
        k      = m_n[i] / (2 * DIVS[i]);
        is_rd  = (m_word[i][29:28] == 2'b10);
        e_mdc  = ((m_n[i] / DIVS[i]) % 2) == 1;
        e_oe   = !is_rd || (k < 16);
        e_out  = e_oe ? m_word[i][31-k] : 1'b0;
        e_busy = 1'b1;
      end else begin
        e_mdc = 1'b0; e_oe = 1'b0; e_out = 1'b0; e_busy = 1'b0;
      end
      check($sformatf("dut%0d mdc", i),      a_mdc[i],  e_mdc);
      check($sformatf("dut%0d mdio_oe", i),  a_oe[i],   e_oe);
      check($sformatf("dut%0d mdio_out", i), a_out[i],  e_out);
      check($sformatf("dut%0d busy", i),     a_busy[i], e_busy);
      check($sformatf("dut%0d data_rdy", i), a_rdy[i],  m_rdy[i]);
      check($sformatf("dut%0d rd_data", i),  a_rd[i],   m_rd[i]);
      // Receiver: present the next read bit after each falling MDC once the line is released.
      if (a_oe[i] || !a_busy[i]) rx_idx[i] = 0;
      else if (prev_mdc[i] && !a_mdc[i] && rx_idx[i] < 16) begin
        rx_bit[i] = rx_word[i][15 - rx_idx[i]];
        rx_idx[i] = rx_idx[i] + 1;
      end
      prev_mdc[i] = a_mdc[i];
    end
  end

  task automatic at(input int n);
    while (cyc < n) begin @(posedge clk); #1; end
  endtask

  task automatic launch(input logic [31:0] w, output int t0);
    t_data = w;
    start  = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    t0    = cyc;
  endtask

  task automatic wait_idle(input int budget);
    int c = 0;
    while ((u_if1.busy || u_if3.busy) && c < budget) begin @(posedge clk); #1; c++; end
    check("idle_wait", {u_if3.busy, u_if1.busy}, 0);
  endtask

  int          t0;
  logic [15:0] pat;

  initial begin
    rst = 1'b1; start = 1'b0; t_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset busy",    u_if1.busy,    0);
    check("reset mdc",     u_if1.mdc,     0);
    check("reset oe",      u_if1.mdio_oe, 0);
    check("reset rd_data", u_if3.rd_data, 16'h0000);
    rst = 1'b0;
    @(posedge clk); #1;

    // Read: both instances, different return words.
    rx_word[0] = 16'h946F;
    rx_word[1] = 16'hA5C3;
    pat = 16'b0110111111100101;
    launch(32'h6FE5946F, t0);
    for (int b = 0; b < 16; b++) begin
      at(t0 + 2 * b + 1);
      check($sformatf("rd out bit %0d", b), u_if1.mdio_out, pat[15-b]);
    end
    at(t0 + 32); check("rd oe fall",  u_if1.mdio_oe, 0);
    at(t0 + 36); check("div3 mdc lo", u_if3.mdc, 0);
    at(t0 + 39); check("div3 mdc hi", u_if3.mdc, 1);
    at(t0 + 42); check("div3 mdc lo2", u_if3.mdc, 0);
    at(t0 + 64);
    check("rd data_rdy", u_if1.data_rdy, 1);
    check("rd rd_data",  u_if1.rd_data,  16'h946F);
    check("rd busy",     u_if1.busy,     0);
    at(t0 + 192);
    check("div3 data_rdy", u_if3.data_rdy, 1);
    check("div3 rd_data",  u_if3.rd_data,  16'hA5C3);
    wait_idle(400);

    // Start while busy is ignored.
    rx_word[0] = 16'h1234;
    rx_word[1] = 16'h8001;
    launch(32'h6FE5946F, t0);
    at(t0 + 9);
    t_data = 32'h5FFF0000; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_idle(400);
    check("ignored rd1", u_if1.rd_data, 16'h1234);
    check("ignored rd3", u_if3.rd_data, 16'h8001);

    // Write leaves rd_data alone.
    launch(32'h5FE5946F, t0);
    at(t0 + 63); check("wr oe held", u_if1.mdio_oe, 1);
    at(t0 + 64);
    check("wr busy fall", u_if1.busy, 0);
    check("wr no rdy",    u_if1.data_rdy, 0);
    check("wr rd kept",   u_if1.rd_data, 16'h1234);
    wait_idle(400);

    // Reset mid-read discards the frame.
    launch(32'h6FE5946F, t0);
    at(t0 + 39);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst busy",    u_if1.busy,     0);
    check("rst oe",      u_if1.mdio_oe,  0);
    check("rst rd1",     u_if1.rd_data,  16'h0000);
    check("rst busy3",   u_if3.busy,     0);
    rst = 1'b0;
    repeat (200) @(posedge clk);
    #1;
    check("rst rd3 after", u_if3.rd_data, 16'h0000);

    // Back-to-back: write then read one clock after completion.
    rx_word[0] = 16'h946F;
    launch(32'h5FE5946F, t0);
    at(t0 + 64);
    t_data = 32'h6FE5946F; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    t0 = cyc;
    check("b2b accepted", u_if1.busy, 1);
    at(t0 + 31); check("b2b oe hi",  u_if1.mdio_oe, 1);
    at(t0 + 32); check("b2b oe lo",  u_if1.mdio_oe, 0);
    at(t0 + 64);
    check("b2b rdy",  u_if1.data_rdy, 1);
    check("b2b data", u_if1.rd_data,  16'h946F);
    wait_idle(400);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/mdio_controller.md
# mdio_controller

MDIO management-interface generator (station side). Takes a 32-bit transaction word from the host logic, serialises it onto MDIO_OUT with a generated MDC, and releases the line during reads to shift in 16 data bits from MDIO_IN. It sits directly upstream of the MDIO transaction receiver. It drives that block's MDC, MDIO_OE and MDIO_OUT inputs and collects the read data it returns.

## Interface
- DIV, default 1: MDC half-period in CLK cycles; legal range ≥1; MDC period = 2·DIV CLK cycles.
- CLK  input  1  system clock; all logic on its rising edge.
- rst  input  1  synchronous, active-high reset.
- MDIO_START  input  1  starts a transaction; sampled only in IDLE.
- T_DATA  input  32  transaction word, latched on the accepted start.
  - Bits [31:30] ST, [29:28] OP, [27:23] PHYAD, [22:18] REGAD, [17:16] TA, [15:0] data.
- MDIO_IN  input  1  serial data returned by the receiver during reads.
- MDC  output  1  management clock; held 0 when idle.
- MDIO_OE  output  1  1 = controller drives MDIO_OUT.
- MDIO_OUT  output  1  serial transmit bit.
- RD_DATA  output  16  last completed read word.
- DATA_RDY  output  1  one-CLK pulse when RD_DATA is updated.
- BUSY  output  1  high while a transaction is in progress.

## Operation
- Reset values: MDC=0, MDIO_OE=0, MDIO_OUT=0, RD_DATA=16'h0000, DATA_RDY=0, BUSY=0; state=IDLE; internal counters 0.
- States: IDLE, WRITE, READ_DRV, READ_SMP.
- IDLE:
  - MDIO_START=1 latches T_DATA and sets BUSY=1, MDIO_OE=1, MDIO_OUT=T_DATA[31], MDC=0.
  - Goes to READ_DRV if T_DATA[29:28]=2'b10; any other OP goes to WRITE.
- A transaction is 32 MDC cycles, k=0..31. Cycle k opens with a falling MDC edge (cycle 0: the accept edge) and has a rising edge DIV CLKs later.
- MDIO_OUT changes only at falling MDC edges. The receiver samples at rising edges.
- WRITE: cycle k drives MDIO_OUT=T_DATA[31-k], with MDIO_OE=1 throughout.
- READ_DRV: cycles 0..15 drive T_DATA[31-k]. The falling edge that opens cycle 16 sets MDIO_OE=0 and MDIO_OUT=0, and the state moves to READ_SMP.
- READ_SMP, cycles 16..31: MDIO_IN is captured into an internal shift register, MSB first, on the CLK edge where MDC rises.
  - Bit captured in cycle k lands at position 31-k.
  - RD_DATA is unchanged until completion.
- Completion, at the edge that would open cycle 32:
  - MDC=0, MDIO_OE=0, MDIO_OUT=0, BUSY=0, state=IDLE.
  - Read only: RD_DATA loads from the shift register and DATA_RDY=1 for exactly that one CLK.
- MDC does not toggle in IDLE.
- MDIO_START while BUSY=1 is ignored; T_DATA is not re-latched.
- rst=1 in any state or cycle forces the reset values on the next edge.
  - No DATA_RDY is produced and the partial read is discarded.
  - rst takes priority over a simultaneous MDIO_START.

## Timing
- Start accepted at edge t0; everything below is relative to it.
- MDC rises at t0+(2k+1)·DIV and falls at t0+(2k+2)·DIV, for k=0..31.
- Completion edge is t0+64·DIV: BUSY falls, plus DATA_RDY for reads. With DIV=1 this is t0+64.
- Read: MDIO_OE falls at t0+32·DIV.
- Write: MDIO_OE stays high for 64·DIV CLK cycles.
- Back-to-back: the earliest next start is sampled at t0+64·DIV+1, since the completion edge itself is not an IDLE sample.
- Internal counters: DIV counter of width clog2(DIV)+1; 5-bit bit counter with no wrap beyond 31.

## Test plan
- Read, DIV=1: T_DATA=32'h6FE5946F, MDIO_START for 1 CLK; bench returns 16'h946F MSB first on rising MDC in cycles 16..31.
  - Expect MDIO_OUT bits 0110111111100101 on cycles 0..15.
  - Expect MDIO_OE falling at t0+32.
  - Expect DATA_RDY pulse at t0+64 with RD_DATA=16'h946F.
  - Expect BUSY=0 at t0+64.
- Write, DIV=1: T_DATA=32'h5FE5946F.
  - Expect MDIO_OUT equal to all 32 bits MSB first, sampled at each rising MDC.
  - Expect MDIO_OE=1 for 64 CLK and BUSY falling at t0+64.
  - Expect no DATA_RDY and RD_DATA unchanged.
- DIV=3 read of 32'h6FE5946F with return data 16'hA5C3.
  - Expect the MDC period to be 6 CLK.
  - Expect completion at t0+192 with RD_DATA=16'hA5C3.
- MDIO_START pulsed again at t0+10 with T_DATA=32'h5FFF0000 during a read: ignored, and the original read completes unchanged.
- rst asserted at t0+40 of a read.
  - Next edge: all outputs at reset values, state IDLE.
  - No DATA_RDY afterwards, and RD_DATA=16'h0000.
- Back-to-back: write, then read started at t0+65.
  - Expect MDC held 0 between the two transactions.
  - Expect the second transaction's timing to match the single-read case exactly.
